// File: rtl/inst_sram_resp_pkg.sv
// Shared widths, default base address and a saturating counter helper
// used by the instruction SRAM responder.
package inst_sram_resp_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned ADDR_W = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = 32'h1c000000;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] c);
    return (&c) ? c : c + DATA_W'(1);
  endfunction

endpackage

// File: rtl/inst_sram_resp_sram_bank.sv
// Word-addressed storage array with byte write enables and a registered,
// read-first output port.
module sram_bank
  import inst_sram_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [BE_W-1:0]       we,
  input  logic [DEPTH_LOG2-1:0] index,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  // Old word is captured before the enabled bytes are replaced.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[index];
      for (int i = 0; i < int'(BE_W); i++) begin
        if (we[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/inst_sram_resp.sv
// Instruction SRAM responder: address decode against BASE_ADDR, sticky
// out-of-range capture, and saturating read/write access counters.
module inst_sram_resp
  import inst_sram_resp_pkg::*;
#(
  parameter int unsigned       DEPTH_LOG2 = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = DEFAULT_BASE_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sram_en,
  input  logic [BE_W-1:0]   sram_we,
  input  logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_wdata,
  output logic [DATA_W-1:0] sram_rdata,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] rd_cnt,
  output logic [DATA_W-1:0] wr_cnt
);

  localparam int unsigned     EXT_W = ADDR_W + 1;
  localparam logic [EXT_W-1:0] LIMIT =
    {1'b0, BASE_ADDR} + (EXT_W'(1) << (DEPTH_LOG2 + 2));

  logic                  access_c;
  logic                  in_range_c;
  logic                  bank_en_c;
  logic [ADDR_W-1:0]     offset_c;
  logic [DEPTH_LOG2-1:0] index_c;
  logic [DATA_W-1:0]     bank_rdata;
  logic                  rdata_valid;

  // Range compare is one bit wider so the upper bound cannot wrap.
  assign in_range_c = ({1'b0, sram_addr} >= {1'b0, BASE_ADDR}) &&
                      ({1'b0, sram_addr} <  LIMIT);
  assign offset_c   = sram_addr - BASE_ADDR;
  assign index_c    = DEPTH_LOG2'(offset_c >> 2);
  assign access_c   = sram_en && !reset;
  assign bank_en_c  = access_c && in_range_c;

  sram_bank #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_bank (
    .clk  (clk),
    .en   (bank_en_c),
    .we   (sram_we),
    .index(index_c),
    .wdata(sram_wdata),
    .rdata(bank_rdata)
  );

  // Out-of-range accesses and reset zero the output without touching the array.
  assign sram_rdata = rdata_valid ? bank_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      err_addr    <= '0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
    end else if (access_c) begin
      rdata_valid <= in_range_c;
      if (sram_we == '0) rd_cnt <= sat_inc(rd_cnt);
      else               wr_cnt <= sat_inc(wr_cnt);
      if (!in_range_c && !err) begin
        err      <= 1'b1;
        err_addr <= sram_addr;
      end
    end
  end

endmodule

// File: tb/tb_inst_sram_resp.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences,
// and random traffic against a behavioural memory model.
module tb_inst_sram_resp;

  localparam logic [31:0] BASE  = 32'h1c000000;
  localparam int          WORDS = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        err;
  logic [31:0] err_addr;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  inst_sram_resp #(
    .DEPTH_LOG2(12),
    .BASE_ADDR (BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sram_en   (sram_en),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .err       (err),
    .err_addr  (err_addr),
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Behavioural model state.
  logic [31:0] m_mem [WORDS];
  logic [31:0] m_rdata;
  logic        m_err;
  logic [31:0] m_err_addr;
  longint      m_rd;
  longint      m_wr;

  function automatic logic [31:0] preload(input int i);
    logic [31:0] v;
    if (i == 0) return 32'h02800c0c;
    if (i == 1) return 32'h11223344;
    v = 32'(i) * 32'h9e3779b9;
    return v ^ 32'h5a5a0f0f;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic model_step(input logic rst, input logic en, input logic [3:0] we,
                            input logic [31:0] addr, input logic [31:0] wdata);
    longint a;
    int     idx;
    logic [31:0] w;
    a = longint'({32'b0, addr});
    if (rst) begin
      m_rdata = 0; m_err = 0; m_err_addr = 0; m_rd = 0; m_wr = 0;
    end else if (en) begin
      if (a >= longint'(BASE) && a < longint'(BASE) + 4 * WORDS) begin
        idx = int'((a - longint'(BASE)) / 4);
        m_rdata = m_mem[idx];
        w = m_mem[idx];
        for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = wdata[8*b +: 8];
        m_mem[idx] = w;
      end else begin
        m_rdata = 0;
        if (!m_err) begin
          m_err = 1; m_err_addr = addr;
        end
      end
      if (we == 4'b0) m_rd = (m_rd == 64'hffffffff) ? m_rd : m_rd + 1;
      else            m_wr = (m_wr == 64'hffffffff) ? m_wr : m_wr + 1;
    end
  endtask

  task automatic step(input logic rst, input logic en, input logic [3:0] we,
                      input logic [31:0] addr, input logic [31:0] wdata);
    reset = rst; sram_en = en; sram_we = we; sram_addr = addr; sram_wdata = wdata;
    @(posedge clk);
    #1;
    model_step(rst, en, we, addr, wdata);
  endtask

  task automatic check_all(input string tag);
    chk32({tag, ".rdata"},    sram_rdata,     m_rdata);
    chk32({tag, ".err"},      {31'b0, err},   {31'b0, m_err});
    chk32({tag, ".err_addr"}, err_addr,       m_err_addr);
    chk32({tag, ".rd_cnt"},   rd_cnt,         32'(m_rd));
    chk32({tag, ".wr_cnt"},   wr_cnt,         32'(m_wr));
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] e_rdata;
    logic        e_err;
    logic [31:0] e_err_addr;
    logic [31:0] e_rd;
    logic [31:0] e_wr;
  } vec_t;

  vec_t vecs [7];

  initial begin
    reset = 1'b1; sram_en = 1'b0; sram_we = 4'h0; sram_addr = 32'h0; sram_wdata = 32'h0;
    for (int i = 0; i < WORDS; i++) begin
      dut.u_bank.mem[i] = preload(i);
      m_mem[i] = preload(i);
    end
    m_rdata = 0; m_err = 0; m_err_addr = 0; m_rd = 0; m_wr = 0;

    vecs[0] = '{1'b1, 1'b0, 4'h0, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0,        32'd0, 32'd0};
    vecs[1] = '{1'b0, 1'b1, 4'h0, 32'h1c000000, 32'h0,        32'h02800c0c, 1'b0, 32'h0,        32'd1, 32'd0};
    vecs[2] = '{1'b0, 1'b1, 4'h5, 32'h1c000004, 32'haabbccdd, 32'h11223344, 1'b0, 32'h0,        32'd1, 32'd1};
    vecs[3] = '{1'b0, 1'b1, 4'h0, 32'h1c000004, 32'h0,        32'h11bb33dd, 1'b0, 32'h0,        32'd2, 32'd1};
    vecs[4] = '{1'b1, 1'b0, 4'h0, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0,        32'd0, 32'd0};
    vecs[5] = '{1'b0, 1'b1, 4'h0, 32'h1bfffffc, 32'h0,        32'h0,        1'b1, 32'h1bfffffc, 32'd1, 32'd0};
    vecs[6] = '{1'b0, 1'b1, 4'h0, 32'h20000000, 32'h0,        32'h0,        1'b1, 32'h1bfffffc, 32'd2, 32'd0};

    for (int v = 0; v < 7; v++) begin
      step(vecs[v].rst, vecs[v].en, vecs[v].we, vecs[v].addr, vecs[v].wdata);
      chk32($sformatf("vec%0d.rdata", v),    sram_rdata,   vecs[v].e_rdata);
      chk32($sformatf("vec%0d.err", v),      {31'b0, err}, {31'b0, vecs[v].e_err});
      chk32($sformatf("vec%0d.err_addr", v), err_addr,     vecs[v].e_err_addr);
      chk32($sformatf("vec%0d.rd_cnt", v),   rd_cnt,       vecs[v].e_rd);
      chk32($sformatf("vec%0d.wr_cnt", v),   wr_cnt,       vecs[v].e_wr);
      check_all($sformatf("vec%0d.model", v));
    end

    // Read then idle: output must hold, counters frozen.
    step(1'b0, 1'b1, 4'h0, 32'h1c000008, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 4'hf, 32'h1c000008, 32'hdeadbeef);
      chk32($sformatf("idle%0d.rdata", k), sram_rdata, preload(2));
      chk32($sformatf("idle%0d.rd_cnt", k), rd_cnt, 32'd3);
      check_all($sformatf("idle%0d", k));
    end

    // Streaming reads with reset landing on the fourth access.
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      step(k == 3, 1'b1, 4'h0, BASE + 32'(4 * k), 32'h0);
      if (k == 3) begin
        chk32("stream_rst.rdata", sram_rdata, 32'h0);
        chk32("stream_rst.rd_cnt", rd_cnt, 32'h0);
      end
      check_all($sformatf("stream%0d", k));
    end
    chk32("stream_end.rd_cnt", rd_cnt, 32'd4);
    step(1'b0, 1'b1, 4'h0, 32'h1c000000, 32'h0);
    chk32("stream_after.rdata", sram_rdata, 32'h02800c0c);

    // Back-to-back write then read of the same word.
    step(1'b0, 1'b1, 4'hf, 32'h1c000040, 32'hcafef00d);
    step(1'b0, 1'b1, 4'h0, 32'h1c000040, 32'h0);
    chk32("raw.rdata", sram_rdata, 32'hcafef00d);

    // Random traffic against the model.
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int n = 0; n < 400; n++) begin
      logic        r_rst;
      logic        r_en;
      logic [3:0]  r_we;
      logic [31:0] r_addr;
      int          sel;
      r_rst = ($urandom_range(0, 49) == 0);
      r_en  = ($urandom_range(0, 3) != 0);
      r_we  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      sel   = $urandom_range(0, 9);
      if (sel < 7)       r_addr = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      else if (sel == 7) r_addr = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
      else if (sel == 8) r_addr = BASE - 32'(4 * $urandom_range(1, 8));
      else               r_addr = ($urandom_range(0, 1) == 0) ? BASE + 32'h4000 + 32'($urandom_range(0, 63))
                                                              : 32'hfffffffc;
      step(r_rst, r_en, r_we, r_addr, $urandom);
      check_all($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/inst_sram_resp.md
INST_SRAM_RESP -- requirements
Module: inst_sram_resp

Interface
- REQ-001: Parameter DEPTH_LOG2, default 12; memory holds 2^DEPTH_LOG2 32-bit words.
- REQ-002: Parameter BASE_ADDR, default 32'h1c000000; byte address of word 0.
- REQ-003: clk  input  1  single clock; all state updates on rising edge.
- REQ-004: reset  input  1  synchronous, active-high reset.
- REQ-005: sram_en  input  1  chip select; access occurs only when high.
- REQ-006: sram_we  input  4  byte write enables; bit i writes wdata[8i+7:8i].
- REQ-007: sram_addr  input  32  byte address; bits [1:0] ignored.
- REQ-008: sram_wdata  input  32  write data.
- REQ-009: sram_rdata  output  32  registered read data.
- REQ-010: err  output  1  sticky out-of-range access flag.
- REQ-011: err_addr  output  32  sram_addr of the first out-of-range access.
- REQ-012: rd_cnt  output  32  count of accepted reads (en=1, we=0).
- REQ-013: wr_cnt  output  32  count of accepted writes (en=1, we!=0).

Function
- REQ-014: Word index SHALL be (sram_addr - BASE_ADDR) >> 2, DEPTH_LOG2 bits wide.
- REQ-015: Access SHALL be in range iff BASE_ADDR <= sram_addr < BASE_ADDR + 4*2^DEPTH_LOG2, compared in 32-bit unsigned arithmetic without wrap.
- REQ-016: Read latency SHALL be exactly one cycle: en=1, we=0, in range at edge N -> sram_rdata = mem[index] after edge N.
- REQ-017: en=1, we!=0, in range SHALL write only enabled bytes at the edge; unenabled bytes unchanged.
- REQ-018: Write access SHALL be read-first: sram_rdata after the edge equals the word before the write.
- REQ-019: en=0 SHALL leave sram_rdata, memory, counters and err unchanged.
- REQ-020: Out-of-range access SHALL load sram_rdata with 32'h0 and suppress any memory write.
- REQ-021: First out-of-range access after reset SHALL set err=1 and capture err_addr; later ones SHALL not change err_addr.
- REQ-022: rd_cnt/wr_cnt SHALL increment by 1 per accepted access, in range or not, and saturate at 32'hffffffff.
- REQ-023: Back-to-back accesses every cycle SHALL be supported with no bubbles; address may change every cycle.
- REQ-024: A read to a word written in the immediately preceding cycle SHALL return the newly written data.
- REQ-025: Memory contents SHALL be loadable only via simulation initialization; no synthesizable preload port.

Reset
- REQ-026: reset=1 at an edge SHALL set sram_rdata=0, err=0, err_addr=0, rd_cnt=0, wr_cnt=0.
- REQ-027: reset SHALL NOT clear memory contents; an access presented with reset=1 SHALL be ignored (no write, no count).
- REQ-028: Reset asserted mid-stream SHALL take effect at that edge; the first access after deassertion behaves as after power-up.

Structure
- REQ-029: Shared package SHALL hold BASE_ADDR default (32'h1c000000), word width 32, and byte-enable width 4.
- REQ-030: Array and byte-write logic SHALL live in sub-module sram_bank (clk, we[3:0], index, wdata, rdata, read-first); decode, error capture and counters stay in inst_sram_resp.

Verification
- REQ-031: Reset, then read 0x1c000000 with word 0 preloaded 0x02800c0c -> rdata 0x02800c0c one cycle later, rd_cnt=1.
- REQ-032: Write 0x1c000004 we=4'b0101 wdata=0xaabbccdd over 0x11223344 -> next-cycle rdata 0x11223344; following read returns 0x11bb33dd; wr_cnt=1.
- REQ-033: Read 0x1bfffffc then 0x20000000 (DEPTH_LOG2=12) -> rdata 0 for each, err=1, err_addr=0x1bfffffc, rd_cnt=2.
- REQ-034: Read A, idle 3 cycles (en=0) -> rdata holds mem[A] for all 3 cycles, rd_cnt unchanged.
- REQ-035: Stream reads 0x1c000000..0x1c00001c every cycle, reset asserted on 4th -> outputs zeroed that edge, memory intact, subsequent read of 0x1c000000 correct.
